// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller: the FSM state
// encoding, the position of the sampler enable window and of the point
// where the sampler's voted bit is consumed, relative to mid-bit.
//
// Contents:
//   PRESCALE_W        width of the oversampling ratio / edge counter
//   CP_OFFSET         consume point = prescale/2 + CP_OFFSET
//   WIN_LO_OFFSET     sampler window starts at prescale/2 - WIN_LO_OFFSET
//   WIN_HI_OFFSET     sampler window ends   at prescale/2 + WIN_HI_OFFSET
//   rx_state_e        FSM state encoding
//   consume_point()   edge count at which sampled_bit is valid
//   in_sample_window() true while the data sampler must be enabled
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int PRESCALE_W    = 6;
    localparam int CP_OFFSET     = 2;
    localparam int WIN_LO_OFFSET = 2;
    localparam int WIN_HI_OFFSET = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // The sampler's vote appears one enable after its window closes, so the
    // controller reads it one count past the end of the window.
    function automatic logic [PRESCALE_W-1:0] consume_point(
        input logic [PRESCALE_W-1:0] prescale
    );
        return (prescale >> 1) + PRESCALE_W'(CP_OFFSET);
    endfunction

    function automatic logic in_sample_window(
        input logic [PRESCALE_W-1:0] edge_cnt,
        input logic [PRESCALE_W-1:0] prescale
    );
        logic [PRESCALE_W-1:0] half;
        half = prescale >> 1;
        return (edge_cnt >= half - PRESCALE_W'(WIN_LO_OFFSET)) &&
               (edge_cnt <= half + PRESCALE_W'(WIN_HI_OFFSET));
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// ----------------------------------------------------------------------------
// edge_bit_counter
// Oversampling timebase for the UART receiver. While enabled, edge_cnt runs
// 0..prescale-1 and wraps; every wrap advances bit_cnt. While disabled both
// counters are held at zero, so the first enabled cycle starts a bit at 0.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   enable    count enable (receiver busy with a frame)
//   prescale  oversampling ratio (8, 16 or 32)
//   edge_cnt  position inside the current bit
//   bit_cnt   index of the current bit within the frame (start bit = 0)
// ----------------------------------------------------------------------------
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int BIT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt
);

    logic wrap;

    assign wrap = (edge_cnt == prescale - PRESCALE_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller of an oversampling UART. Detects the start edge,
// steers an external majority-vote data sampler, deserializes the data bits
// LSB first, checks optional parity and the stop bit, and presents each good
// word with a one-cycle valid pulse.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | line idle, waiting for rx_in low
//   START  | start bit; a high vote at the consume point is a glitch
//   DATA   | shifting in DATA_WIDTH bits, LSB first
//   PARITY | comparing the parity bit against the received word
//   STOP   | checking the stop bit, releasing the word at the bit's end
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   rx_in           raw serial line (start-edge detection only)
//   prescale        oversampling ratio: 8, 16 or 32, static during a frame
//   par_en          parity bit present
//   par_typ         0 = even parity, 1 = odd parity
//   sampled_bit     majority-voted bit from the data sampler
//   data_sample_en  enable for the data sampler
//   p_data          last good received word
//   data_valid      one-cycle pulse when p_data is updated
//   par_err         parity error of the last frame (held until next start)
//   stp_err         stop-bit error of the last frame (held until next start)
// ----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  data_sample_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    // bit_cnt must reach DATA_WIDTH + 2 (start, data, parity, stop).
    localparam int BIT_W = $clog2(DATA_WIDTH + 3);

    rx_state_e             state;
    rx_state_e             state_next;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  cnt_en;
    logic                  at_cp;
    logic                  at_wrap;
    logic                  in_win;
    logic                  last_data_bit;
    logic                  start_frame;
    logic                  shift_en;
    logic                  load_par;
    logic                  load_stp;
    logic                  frame_end;

    assign cnt_en        = (state != ST_IDLE);
    assign at_cp         = (edge_cnt == consume_point(prescale));
    assign at_wrap       = (edge_cnt == prescale - PRESCALE_W'(1));
    assign in_win        = in_sample_window(edge_cnt, prescale);
    assign last_data_bit = (bit_cnt == BIT_W'(DATA_WIDTH));

    edge_bit_counter #(
        .BIT_W (BIT_W)
    ) u_edge_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .prescale (prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        data_sample_en = 1'b0;
        start_frame    = 1'b0;
        shift_en       = 1'b0;
        load_par       = 1'b0;
        load_stp       = 1'b0;
        frame_end      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_in) begin
                    start_frame = 1'b1;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                data_sample_en = in_win;
                if (at_cp && sampled_bit) begin
                    state_next = ST_IDLE;
                end else if (at_wrap) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                data_sample_en = in_win;
                shift_en       = at_cp;
                if (at_wrap && last_data_bit) begin
                    state_next = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                data_sample_en = in_win;
                load_par       = at_cp;
                if (at_wrap) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                data_sample_en = in_win;
                load_stp       = at_cp;
                if (at_wrap) begin
                    frame_end  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Flags are updated at the consume point, well before the stop-bit wrap,
    // so frame_end sees the final error status of this frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg  <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start_frame) begin
                par_err <= 1'b0;
                stp_err <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= DATA_WIDTH'({sampled_bit, shift_reg} >> 1);
            end
            if (load_par) begin
                par_err <= ((^shift_reg) ^ par_typ) != sampled_bit;
            end
            if (load_stp) begin
                stp_err <= !sampled_bit;
            end
            if (frame_end && !par_err && !stp_err) begin
                data_valid <= 1'b1;
                p_data     <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       data_sample_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_pdata;
    logic       pending_start;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_in          (rx_in),
        .prescale       (prescale),
        .par_en         (par_en),
        .par_typ        (par_typ),
        .sampled_bit    (sampled_bit),
        .data_sample_en (data_sample_en),
        .p_data         (p_data),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .stp_err        (stp_err)
    );

    typedef struct {
        int         p;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       pbit;
        logic       sbit;
        logic       b2b;
        int         gap;
        logic       e_v;
        logic       e_pe;
        logic       e_se;
        logic [7:0] e_pd;
    } vec_t;

    vec_t vecs [6];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h want 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Sampler enable window relative to the bit start: prescale/2-2 .. prescale/2+1.
    function automatic logic win(input int off, input int p);
        return (off >= p / 2 - 2) && (off <= p / 2 + 1);
    endfunction

    task automatic idle_cycles(input int n, input logic e_pe, input logic e_se);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            rx_in       = 1'b1;
            sampled_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_bit("idle data_valid", data_valid, 1'b0);
            check_bit("idle dse", data_sample_en, 1'b0);
            check_bit("idle par_err hold", par_err, e_pe);
            check_bit("idle stp_err hold", stp_err, e_se);
            check_byte("idle p_data hold", p_data, model_pdata);
        end
    endtask

    // Drives one serial frame. Line bit k spans frame cycles k*p .. k*p+p-1;
    // the receiver lags the line by one cycle, so its bit k begins at k*p+1.
    // sampled_bit carries the true bit only at the consume point
    // (prescale/2+2 into the receiver's bit) and the inverse elsewhere.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe,
                              input logic pt, input logic pbit, input logic sbit,
                              input logic b2b, input int abort_at,
                              output logic a_dv, output logic a_pe, output logic a_se,
                              output logic a_dse, output logic [7:0] a_pd);
        logic bits [0:10];
        int   nb, n, first, off, dk;
        logic aborted;
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[j + 1] = d[j];
        nb = 9;
        if (pe) begin
            bits[9] = pbit;
            nb = 10;
        end
        bits[nb] = sbit;
        nb = nb + 1;
        n = nb * p;
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        first    = pending_start ? 1 : 0;
        pending_start = 1'b0;
        aborted  = 1'b0;
        off      = 0;
        a_dv = 1'b0; a_pe = 1'b0; a_se = 1'b0; a_dse = 1'b0; a_pd = 8'h00;
        for (int i = first; i <= n; i++) begin
            @(posedge clk); #1;
            rx_in = (i / p < nb) ? bits[i / p] : 1'b1;
            if (i == 0) begin
                sampled_bit = 1'b1;
            end else begin
                dk  = (i - 1) / p;
                off = (i - 1) % p;
                sampled_bit = (off == p / 2 + 2) ? bits[dk] : ~bits[dk];
            end
            @(negedge clk);
            if (i >= 1) begin
                check_bit("frame dse", data_sample_en, win(off, p));
                check_bit("frame data_valid", data_valid, 1'b0);
                check_byte("frame p_data hold", p_data, model_pdata);
            end
            if (abort_at > 0 && i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            @(posedge clk); #1;
            rx_in       = b2b ? 1'b0 : 1'b1;
            sampled_bit = 1'b1;
            @(negedge clk);
            a_dv  = data_valid;
            a_pe  = par_err;
            a_se  = stp_err;
            a_dse = data_sample_en;
            a_pd  = p_data;
            pending_start = b2b;
        end
    endtask

    task automatic check_result(input string tag, input logic a_dv, input logic a_pe,
                                input logic a_se, input logic a_dse, input logic [7:0] a_pd,
                                input logic e_v, input logic e_pe, input logic e_se,
                                input logic [7:0] e_pd);
        check_bit({tag, " data_valid"}, a_dv, e_v);
        check_bit({tag, " par_err"}, a_pe, e_pe);
        check_bit({tag, " stp_err"}, a_se, e_se);
        check_bit({tag, " dse"}, a_dse, 1'b0);
        check_byte({tag, " p_data"}, a_pd, e_pd);
    endtask

    initial begin
        logic       a_dv, a_pe, a_se, a_dse;
        logic [7:0] a_pd;
        int         p;
        logic [7:0] d;
        logic       pe, pt, pbit, sbit, b2b, e_pe, e_se, e_v;

        rst = 1'b0; rx_in = 1'b1; sampled_bit = 1'b0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        pending_start = 1'b0; model_pdata = 8'h00;

        //            p   data    pe    pt    pbit  sbit  b2b  gap  v     perr  serr  p_data
        vecs[0] = '{ 8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{32, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{ 8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h55};
        vecs[5] = '{ 8, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'hAA};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset dse", data_sample_en, 1'b0);
        check_bit("reset data_valid", data_valid, 1'b0);
        check_bit("reset par_err", par_err, 1'b0);
        check_bit("reset stp_err", stp_err, 1'b0);
        check_byte("reset p_data", p_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(3, 1'b0, 1'b0);

        foreach (vecs[v]) begin
            send_frame(vecs[v].p, vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].pbit,
                       vecs[v].sbit, vecs[v].b2b, 0, a_dv, a_pe, a_se, a_dse, a_pd);
            check_result($sformatf("vec%0d", v), a_dv, a_pe, a_se, a_dse, a_pd,
                         vecs[v].e_v, vecs[v].e_pe, vecs[v].e_se, vecs[v].e_pd);
            model_pdata = vecs[v].e_pd;
            if (!vecs[v].b2b) idle_cycles(vecs[v].gap, vecs[v].e_pe, vecs[v].e_se);
        end

        // Reset in the middle of the data bits of 0xFF, then a clean 0x12.
        send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40,
                   a_dv, a_pe, a_se, a_dse, a_pd);
        @(posedge clk); #1;
        rst   = 1'b0;
        rx_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_bit("in-reset dse", data_sample_en, 1'b0);
            check_bit("in-reset data_valid", data_valid, 1'b0);
            check_bit("in-reset par_err", par_err, 1'b0);
            check_bit("in-reset stp_err", stp_err, 1'b0);
            check_byte("in-reset p_data", p_data, 8'h00);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        model_pdata = 8'h00;
        idle_cycles(2, 1'b0, 1'b0);
        send_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,
                   a_dv, a_pe, a_se, a_dse, a_pd);
        check_result("post-reset", a_dv, a_pe, a_se, a_dse, a_pd, 1'b1, 1'b0, 1'b0, 8'h12);
        model_pdata = 8'h12;
        idle_cycles(2, 1'b0, 1'b0);

        // Start glitch: line low for two clocks, the sampler votes high.
        prescale = 6'd8; par_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            rx_in       = (i < 2) ? 1'b0 : 1'b1;
            sampled_bit = 1'b1;
            @(negedge clk);
            check_bit("glitch dse", data_sample_en, (i >= 1) && win(i - 1, 8));
            check_bit("glitch data_valid", data_valid, 1'b0);
            check_bit("glitch par_err", par_err, 1'b0);
            check_bit("glitch stp_err", stp_err, 1'b0);
            check_byte("glitch p_data", p_data, 8'h12);
        end
        idle_cycles(2, 1'b0, 1'b0);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,
                   a_dv, a_pe, a_se, a_dse, a_pd);
        check_result("post-glitch", a_dv, a_pe, a_se, a_dse, a_pd, 1'b1, 1'b0, 1'b0, 8'h81);
        model_pdata = 8'h81;
        idle_cycles(1, 1'b0, 1'b0);

        // Random frames against the frame-level reference model.
        for (int r = 0; r < 30; r++) begin
            p    = 8 << $urandom_range(0, 2);
            d    = 8'($urandom);
            pe   = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            pbit = (^d) ^ pt;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            sbit = ($urandom_range(0, 3) != 0);
            b2b  = ($urandom_range(0, 2) == 0) && (r != 29);
            e_pe = pe && (pbit != ((^d) ^ pt));
            e_se = !sbit;
            e_v  = !e_pe && !e_se;
            send_frame(p, d, pe, pt, pbit, sbit, b2b, 0, a_dv, a_pe, a_se, a_dse, a_pd);
            if (e_v) model_pdata = d;
            check_result($sformatf("rand%0d", r), a_dv, a_pe, a_se, a_dse, a_pd,
                         e_v, e_pe, e_se, model_pdata);
            if (!b2b) idle_cycles($urandom_range(0, 3), e_pe, e_se);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
